// File: rtl/lc3b_muldiv_pkg.sv
// rtl/lc3b_muldiv_pkg.sv - shared types for the iterative multiply/divide unit
package lc3b_muldiv_pkg;

    typedef enum logic [1:0] {
        md_idle,
        md_run,
        md_done
    } lc3b_muldiv_state;

    typedef enum logic {
        md_mul,
        md_div
    } lc3b_muldiv_op;

endpackage

// File: rtl/lc3b_muldiv_step.sv
// rtl/lc3b_muldiv_step.sv - one combinational shift-add / restoring-divide iteration
module lc3b_muldiv_step
    import lc3b_muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  lc3b_muldiv_op      op,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out,
    output logic               q_bit
);

    // Multiply: acc = {partial product high, remaining multiplier bits}, LSB first.
    // Divide:   acc = {partial remainder, remaining dividend bits}, MSB first;
    //           the quotient bit is shifted in by the caller through q_bit.
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_trial;

    // Single iteration of the selected operation
    always_comb begin
        mul_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                  + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Shifted remainder can need WIDTH+1 bits; a set top bit of the
        // difference means the trial subtraction borrowed.
        div_trial = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        acc_out   = '0;
        q_bit     = 1'b0;
        if (op == md_mul) begin
            acc_out = {mul_sum, acc_in[WIDTH-1:1]};
        end else begin
            q_bit = ~div_trial[WIDTH];
            if (q_bit) begin
                acc_out = {div_trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/lc3b_muldiv.sv
// rtl/lc3b_muldiv.sv - iterative unsigned multiply/divide unit with pipeline stall
module lc3b_muldiv
    import lc3b_muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mult_op,
    input  logic             div_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);

    lc3b_muldiv_state   state_q, state_d;
    lc3b_muldiv_op      op_q, op_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;

    logic               accept;
    logic               div_by_zero;
    lc3b_muldiv_op      new_op;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;

    // A start is taken only from IDLE, with a real op, and not while squashed
    assign accept      = (state_q == md_idle) & start & (mult_op | div_op) & ~flush;
    assign new_op      = mult_op ? md_mul : md_div;
    assign div_by_zero = (new_op == md_div) && (b == '0);

    lc3b_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (op_q),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (step_acc),
        .q_bit   (step_q)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= md_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: divide by zero short-circuits straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            md_idle: begin
                if (accept) begin
                    state_d = div_by_zero ? md_done : md_run;
                end
            end
            md_run: begin
                if (flush) begin
                    state_d = md_idle;
                end else if (count_q == '0) begin
                    state_d = md_done;
                end
            end
            md_done: state_d = md_idle;
            default: state_d = md_idle;
        endcase
    end

    // Outputs: stall covers the accepting cycle combinationally, then RUN
    always_comb begin
        busy  = (state_q == md_run) || (state_q == md_done);
        stall = accept || (state_q == md_run);
        done  = (state_q == md_done) && !flush;
    end

    // Datapath next values: load on accept, iterate in RUN, capture on last step
    always_comb begin
        op_d        = op_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        count_d     = count_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        case (state_q)
            md_idle: begin
                if (accept) begin
                    op_d    = new_op;
                    opnd_d  = b;
                    acc_d   = {{WIDTH{1'b0}}, a};
                    count_d = COUNT_INIT;
                    if (div_by_zero) begin
                        result_d    = '1;
                        remainder_d = a;
                    end
                end
            end
            md_run: begin
                if (!flush) begin
                    acc_d = step_acc;
                    if (op_q == md_div) begin
                        acc_d[0] = step_q;
                    end
                    count_d = count_q - 1'b1;
                    if (count_q == '0) begin
                        count_d     = '0;
                        result_d    = acc_d[WIDTH-1:0];
                        remainder_d = acc_d[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= md_mul;
            opnd_q      <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            result_q    <= '0;
            remainder_q <= '0;
        end else begin
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
        end
    end

    assign result    = result_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_lc3b_muldiv.sv
// tb/tb_lc3b_muldiv.sv - self-checking bench for lc3b_muldiv
module tb_lc3b_muldiv;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         mult_op = 1'b0;
    logic         div_op = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, stall, done;
    logic [W-1:0] result, remainder;

    int total = 0;
    int bad = 0;

    lc3b_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mult_op   (mult_op),
        .div_op    (div_op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .result    (result),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles left until DONE, plus the answer computed with plain arithmetic
    int           m_left = 0;
    bit           m_in_done = 1'b0;
    logic [W-1:0] m_res = '0, m_rem = '0, p_res = '0, p_rem = '0;
    logic [31:0]  prod;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left = 0; m_in_done = 1'b0; m_res = '0; m_rem = '0;
        end else if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (m_left > 0) begin
            if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_in_done = 1'b1; m_res = p_res; m_rem = p_rem;
                end
            end
        end else if (start && (mult_op || div_op) && !flush) begin
            if (mult_op) begin
                prod = {16'b0, a} * {16'b0, b};
                p_res = prod[15:0]; p_rem = prod[31:16]; m_left = W;
            end else if (b == 0) begin
                m_in_done = 1'b1; m_res = '1; m_rem = a;
            end else begin
                p_res = a / b; p_rem = a % b; m_left = W;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        bit m_idle;
        #2;
        m_idle = (m_left == 0) && !m_in_done;
        chk("busy", busy, (m_left > 0) || m_in_done);
        chk("stall", stall, (m_left > 0) || (m_idle && start && (mult_op || div_op) && !flush));
        chk("done", done, m_in_done && !flush);
        chk("result", result, m_res);
        chk("remainder", remainder, m_rem);
    end

    task automatic do_op(input bit is_mul, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] er, input logic [W-1:0] erem, input int elat,
                         input string tag);
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1; mult_op = is_mul; div_op = !is_mul; a = av; b = bv;
        #3 chk({tag, "_stall_t0"}, stall, 1);
        n = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0; mult_op = 1'b0; div_op = 1'b0;
            end
            #3;
            if (done) begin
                seen = 1'b1;
                chk({tag, "_latency"}, n, elat);
                chk({tag, "_result"}, result, er);
                chk({tag, "_remainder"}, remainder, erem);
                chk({tag, "_stall_done"}, stall, 0);
            end
        end
        if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        int  k;
        bit  seen;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_remainder", remainder, 0);
        @(negedge clk); @(negedge clk);
        #3 reset_n = 1'b1;

        do_op(1'b1, 16'd7, 16'd6, 16'h002A, 16'h0000, 17, "mul7x6");
        do_op(1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 17, "mulmax");
        do_op(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 17, "div100_7");
        do_op(1'b0, 16'd5, 16'd9, 16'd0, 16'd5, 17, "div5_9");
        do_op(1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, "div0");

        // Flush in RUN at t0+5
        @(negedge clk);
        start = 1'b1; mult_op = 1'b1; div_op = 1'b0; a = 16'd11; b = 16'd13;
        for (k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; mult_op = 1'b0; end
            if (k == 5) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        #3;
        chk("flush_busy", busy, 0);
        chk("flush_result_kept", result, 16'hFFFF);
        chk("flush_rem_kept", remainder, 16'h1234);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk); #3;
            if (done) seen = 1'b1;
        end
        chk("flush_no_done", seen, 0);
        do_op(1'b1, 16'd3, 16'd3, 16'd9, 16'd0, 17, "mul3x3");

        // Asynchronous reset at t0+8 of a running multiply
        @(negedge clk);
        start = 1'b1; mult_op = 1'b1; div_op = 1'b0; a = 16'd7; b = 16'd6;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin start = 1'b0; mult_op = 1'b0; end
        end
        #3 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_stall", stall, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_remainder", remainder, 0);
        @(negedge clk); @(negedge clk);
        #3 reset_n = 1'b1;
        do_op(1'b1, 16'd2, 16'd2, 16'd4, 16'd0, 17, "mul2x2");

        // Randomized traffic, including starts while busy, zero divisors and flushes
        repeat (700) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            mult_op = 1'($urandom_range(0, 1));
            div_op  = 1'($urandom_range(0, 1));
            a       = W'($urandom);
            b       = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            flush   = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        start = 1'b0; mult_op = 1'b0; div_op = 1'b0; flush = 1'b0;
        repeat (25) @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
